// File: rtl/id_stage.sv
// id_stage: decode/register-read stage with an 8x16 register file and a per-register
// pending-write scoreboard. Optional macro WB_BYPASS_EN forwards same-edge writeback data.
module id_stage #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    if_valid,
  input  logic [DW-1:0]           if_ir,
  input  logic [DW-1:0]           if_pc,
  output logic                    id_ready,
  input  logic                    flush,
  input  logic                    wb_en,
  input  logic                    wb_kill,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [DW-1:0]           wb_data,
  output logic                    id_valid,
  output logic [DW-1:0]           ir,
  output logic [DW-1:0]           pc,
  output logic [DW-1:0]           sr1,
  output logic [DW-1:0]           sr2,
  output logic                    id_wen,
  output logic [$clog2(NREG)-1:0] id_rd
);
  localparam int AW = $clog2(NREG);
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic          use1;
    logic          use2;
    logic          wr;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
  } dec_t;

  logic [DW-1:0]   r_rf [NREG];
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  dec_t            w_dec;
  logic            w_wbw, w_byp1, w_byp2, w_haz, w_acc;
  logic [DW-1:0]   w_rdat1, w_rdat2;

  always_comb begin
    w_dec      = '0;
    w_dec.rd   = if_ir[13:11];
    w_dec.rs1  = if_ir[10:8];
    w_dec.rs2  = if_ir[7:5];
    case (if_ir[15:14])
      2'b00: begin
        w_dec.use1 = 1'b1;
        w_dec.use2 = 1'b1;
        w_dec.wr   = (w_dec.rd != '0);
      end
      2'b01:   w_dec.wr   = (w_dec.rd != '0);
      2'b10:   w_dec.use1 = (w_dec.rd == 3'b001);
      default: ;
    endcase
  end

  // A retiring (non-killed) write to r1..r7 this edge; bypass lets a source read it directly.
  assign w_wbw   = wb_en & ~wb_kill & (wb_addr != '0);
  assign w_byp1  = BYP & w_wbw & (wb_addr == w_dec.rs1);
  assign w_byp2  = BYP & w_wbw & (wb_addr == w_dec.rs2);
  assign w_haz   = (w_dec.use1 & r_pend[w_dec.rs1] & ~w_byp1)
                 | (w_dec.use2 & r_pend[w_dec.rs2] & ~w_byp2)
                 | (w_dec.wr   & r_pend[w_dec.rd]);
  assign id_ready = RSTN & (~w_haz | flush);
  assign w_acc   = if_valid & ~flush & ~w_haz;
  assign w_rdat1 = w_byp1 ? wb_data : r_rf[w_dec.rs1];
  assign w_rdat2 = w_byp2 ? wb_data : r_rf[w_dec.rs2];

  // Clear on retire first, then set on issue, so a same-edge set wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_en) w_pend_nxt[wb_addr] = 1'b0;
    if (w_acc & w_dec.wr) w_pend_nxt[w_dec.rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_wbw) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      id_valid <= 1'b0;
      ir       <= '0;
      pc       <= '0;
      sr1      <= '0;
      sr2      <= '0;
      id_wen   <= 1'b0;
      id_rd    <= '0;
    end else if (w_acc) begin
      id_valid <= 1'b1;
      ir       <= if_ir;
      pc       <= if_pc;
      sr1      <= w_rdat1;
      sr2      <= w_rdat2;
      id_wen   <= w_dec.wr;
      id_rd    <= w_dec.rd;
    end else begin
      id_valid <= 1'b0;
      ir       <= '0;
      id_wen   <= 1'b0;
    end
  end
endmodule
